// File: rtl/spi_register_writer.sv
// SPI mode-0 slave that turns "16-bit register number + value bytes" frames into
// one-cycle parallel register-write strobes for the synth core.
module spi_register_writer #(
    parameter int SYNC_STAGES    = 2,
    parameter int ADDR_INCREMENT = 1
) (
    input  logic        i_Clock,
    input  logic        i_Reset,
    input  logic        i_SPI_SCK,
    input  logic        i_SPI_MOSI,
    input  logic        i_SPI_CS_N,
    output logic        o_RegisterWriteEnable,
    output logic [15:0] o_RegisterWriteNumber,
    output logic [7:0]  o_RegisterWriteValue,
    output logic        o_FrameError,
    output logic        o_Busy
);

    // state        | meaning
    // ST_WAIT_IDLE | after reset; wait for CS_N high so a half-seen frame is dropped
    // ST_IDLE      | armed, waiting for CS_N low
    // ST_HEADER    | shifting the 16-bit register number
    // ST_DATA      | shifting value bytes; each whole byte issues one write
    typedef enum logic [1:0] {
        ST_WAIT_IDLE,
        ST_IDLE,
        ST_HEADER,
        ST_DATA
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic                   sck_prev_q, sck_prev_d;
    logic [3:0]             bit_cnt_q, bit_cnt_d;
    logic [14:0]            shift_q, shift_d;
    logic [15:0]            addr_q, addr_d;
    logic                   we_q, we_d;
    logic [15:0]            num_q, num_d;
    logic [7:0]             val_q, val_d;
    logic                   err_q, err_d;

    logic        sck_s;
    logic        mosi_s;
    logic        cs_s;
    logic        sck_rise;
    logic [15:0] shift_in;

    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev_q;
    assign shift_in = {shift_q, mosi_s};

    always_comb begin
        state_d     = state_q;
        sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], i_SPI_SCK};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], i_SPI_MOSI};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], i_SPI_CS_N};
        sck_prev_d  = sck_s;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        addr_d      = addr_q;
        we_d        = 1'b0;
        num_d       = num_q;
        val_d       = val_q;
        err_d       = 1'b0;

        case (state_q)
            ST_WAIT_IDLE: begin
                if (cs_s) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (!cs_s) begin
                    state_d   = ST_HEADER;
                    bit_cnt_d = 4'd0;
                end
            end
            ST_HEADER: begin
                if (cs_s) begin
                    state_d = ST_IDLE;
                    err_d   = (bit_cnt_q != 4'd0);
                end else if (sck_rise) begin
                    shift_d   = shift_in[14:0];
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd15) begin
                        addr_d    = shift_in;
                        state_d   = ST_DATA;
                        bit_cnt_d = 4'd0;
                    end
                end
            end
            ST_DATA: begin
                if (cs_s) begin
                    state_d = ST_IDLE;
                    err_d   = (bit_cnt_q != 4'd0);
                end else if (sck_rise) begin
                    shift_d   = shift_in[14:0];
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) begin
                        // Strobe, number and value are registered together so they appear as one word.
                        we_d      = 1'b1;
                        num_d     = addr_q;
                        val_d     = shift_in[7:0];
                        addr_d    = addr_q + 16'(ADDR_INCREMENT);
                        bit_cnt_d = 4'd0;
                    end
                end
            end
            default: state_d = ST_WAIT_IDLE;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            // CS chain clears to 0 (asserted) so WAIT_IDLE must see a real CS_N high.
            state_q     <= ST_WAIT_IDLE;
            sck_sync_q  <= '0;
            mosi_sync_q <= '0;
            cs_sync_q   <= '0;
            sck_prev_q  <= 1'b0;
            bit_cnt_q   <= 4'd0;
            shift_q     <= 15'd0;
            addr_q      <= 16'd0;
            we_q        <= 1'b0;
            num_q       <= 16'd0;
            val_q       <= 8'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sck_sync_q  <= sck_sync_d;
            mosi_sync_q <= mosi_sync_d;
            cs_sync_q   <= cs_sync_d;
            sck_prev_q  <= sck_prev_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            num_q       <= num_d;
            val_q       <= val_d;
            err_q       <= err_d;
        end
    end

    assign o_RegisterWriteEnable = we_q;
    assign o_RegisterWriteNumber = num_q;
    assign o_RegisterWriteValue  = val_q;
    assign o_FrameError          = err_q;
    assign o_Busy                = (state_q == ST_HEADER) || (state_q == ST_DATA);

endmodule

// File: tb/tb_spi_register_writer.sv
// Scoreboard bench for spi_register_writer: tasks drive SPI frames and queue the
// writes they should cause; a monitor pops and compares on every strobe.
module tb_spi_register_writer;

    localparam int HALF = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        sck;
    logic        mosi;
    logic        cs_n;
    logic        we;
    logic [15:0] num;
    logic [7:0]  val;
    logic        ferr;
    logic        busy;

    int compared   = 0;
    int mismatched = 0;
    int strobes    = 0;
    int err_pulses = 0;
    logic [23:0] exp_q[$];
    logic        we_prev  = 1'b0;
    logic        err_prev = 1'b0;

    spi_register_writer #(.SYNC_STAGES(2), .ADDR_INCREMENT(1)) dut (
        .i_Clock              (clk),
        .i_Reset              (rst),
        .i_SPI_SCK            (sck),
        .i_SPI_MOSI           (mosi),
        .i_SPI_CS_N           (cs_n),
        .o_RegisterWriteEnable(we),
        .o_RegisterWriteNumber(num),
        .o_RegisterWriteValue (val),
        .o_FrameError         (ferr),
        .o_Busy               (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        logic [23:0] e;
        if (we === 1'b1) begin
            strobes++;
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("FAIL write_unexpected: got num=%h val=%h, required no write", num, val);
            end else begin
                e = exp_q.pop_front();
                if ({num, val} !== e) begin
                    mismatched++;
                    $display("FAIL write_data: got num=%h val=%h, required num=%h val=%h",
                             num, val, e[23:8], e[7:0]);
                end
            end
            if (ferr === 1'b1) begin
                compared++;
                mismatched++;
                $display("FAIL we_err_overlap: got we=1 err=1, required not both");
            end
        end
        if (ferr === 1'b1) err_pulses++;
        if ((we === 1'b1 && we_prev) || (ferr === 1'b1 && err_prev)) begin
            compared++;
            mismatched++;
            $display("FAIL pulse_width: got we=%b/%b err=%b/%b, required single-cycle", we_prev, we, err_prev, ferr);
        end
        we_prev  = (we === 1'b1);
        err_prev = (ferr === 1'b1);
    end

    task automatic half_period();
        repeat (HALF) @(posedge clk);
        #1;
    endtask

    task automatic spi_bits(input logic [23:0] data, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            mosi = data[i];
            half_period();
            sck = 1'b1;
            half_period();
            sck = 1'b0;
        end
    endtask

    task automatic cs_release();
        half_period();
        cs_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
    endtask

    task automatic check_frame(input string name, input int s0, input int e0,
                               input int exp_strobes, input int exp_errs);
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL %s_missing: got %0d writes outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
        compared++;
        if (strobes - s0 != exp_strobes) begin
            mismatched++;
            $display("FAIL %s_strobes: got %0d, required %0d", name, strobes - s0, exp_strobes);
        end
        compared++;
        if (err_pulses - e0 != exp_errs) begin
            mismatched++;
            $display("FAIL %s_errors: got %0d, required %0d", name, err_pulses - e0, exp_errs);
        end
        compared++;
        if (busy !== 1'b0) begin
            mismatched++;
            $display("FAIL %s_busy_after: got %b, required 0", name, busy);
        end
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        cs_n = 1'b1;
        sck  = 1'b0;
        mosi = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        compared++;
        if ({we, num, val, ferr, busy} !== 27'd0) begin
            mismatched++;
            $display("FAIL reset_outputs: got we=%b num=%h val=%h err=%b busy=%b, required all 0",
                     we, num, val, ferr, busy);
        end
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        int s0 = strobes;
        int e0 = err_pulses;
        exp_q.push_back({16'hC005, 8'h7F});
        cs_n = 1'b0;
        spi_bits(24'hC005, 16);
        compared++;
        if (busy !== 1'b1) begin
            mismatched++;
            $display("FAIL single_busy: got %b, required 1", busy);
        end
        spi_bits(24'h7F, 8);
        cs_release();
        check_frame("single", s0, e0, 1, 0);
    endtask

    task automatic test_burst();
        int s0 = strobes;
        int e0 = err_pulses;
        exp_q.push_back({16'hC100, 8'h11});
        exp_q.push_back({16'hC101, 8'h22});
        exp_q.push_back({16'hC102, 8'h33});
        cs_n = 1'b0;
        spi_bits(24'hC100, 16);
        spi_bits(24'h11, 8);
        spi_bits(24'h22, 8);
        spi_bits(24'h33, 8);
        cs_release();
        check_frame("burst", s0, e0, 3, 0);
        repeat (20) @(posedge clk);
        #1;
        compared++;
        if ({num, val} !== {16'hC102, 8'h33}) begin
            mismatched++;
            $display("FAIL burst_hold: got num=%h val=%h, required num=c102 val=33", num, val);
        end
    endtask

    task automatic test_wrap();
        int s0 = strobes;
        int e0 = err_pulses;
        exp_q.push_back({16'hFFFF, 8'hAA});
        exp_q.push_back({16'h0000, 8'hBB});
        cs_n = 1'b0;
        spi_bits(24'hFFFF, 16);
        spi_bits(24'hAA, 8);
        spi_bits(24'hBB, 8);
        cs_release();
        check_frame("wrap", s0, e0, 2, 0);
    endtask

    task automatic test_abort();
        int s0 = strobes;
        int e0 = err_pulses;
        cs_n = 1'b0;
        spi_bits(24'hC005, 16);
        spi_bits(24'h5, 3);
        cs_release();
        check_frame("abort", s0, e0, 0, 1);
        s0 = strobes;
        e0 = err_pulses;
        exp_q.push_back({16'h8000, 8'h01});
        cs_n = 1'b0;
        spi_bits(24'h8000, 16);
        spi_bits(24'h01, 8);
        cs_release();
        check_frame("after_abort", s0, e0, 1, 0);
    endtask

    task automatic test_header_only();
        int s0 = strobes;
        int e0 = err_pulses;
        cs_n = 1'b0;
        spi_bits(24'h1234, 16);
        cs_release();
        check_frame("header_only", s0, e0, 0, 0);
        s0 = strobes;
        e0 = err_pulses;
        cs_n = 1'b0;
        spi_bits(24'h15, 5);
        cs_release();
        check_frame("partial_header", s0, e0, 0, 1);
    endtask

    task automatic test_reset_midframe();
        int s0 = strobes;
        int e0 = err_pulses;
        cs_n = 1'b0;
        spi_bits(24'h2D5, 10);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        spi_bits(24'h1A5C, 14);
        half_period();
        compared++;
        if (busy !== 1'b0) begin
            mismatched++;
            $display("FAIL midreset_busy: got %b, required 0", busy);
        end
        cs_release();
        check_frame("midreset", s0, e0, 0, 0);
        s0 = strobes;
        e0 = err_pulses;
        exp_q.push_back({16'hC200, 8'h44});
        cs_n = 1'b0;
        spi_bits(24'hC200, 16);
        spi_bits(24'h44, 8);
        cs_release();
        check_frame("after_midreset", s0, e0, 1, 0);
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst();
        test_wrap();
        test_abort();
        test_header_only();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/spi_register_writer.md
Name: spi_register_writer

Overview:
- SPI slave front end that converts serial host traffic into the synth core's parallel register-write interface.
- Its outputs connect directly to the core's i_RegisterWriteEnable, i_RegisterWriteNumber and i_RegisterWriteValue.
- Each chip-select frame carries a 16-bit register number followed by one or more value bytes. Successive bytes write successive register numbers, so one frame can load a parameter across consecutive voice-operator indices.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the synchronisers on SCK, MOSI and CS_N (minimum 2)
ADDR_INCREMENT, 1, amount added to the register number after each data byte in a burst

Ports:
i_Clock  input  1  system clock; all logic on its rising edge
i_Reset  input  1  synchronous, active-high reset
i_SPI_SCK  input  1  SPI clock, asynchronous to i_Clock; mode 0
i_SPI_MOSI  input  1  SPI data in, MSB first; sampled on SCK rising edge
i_SPI_CS_N  input  1  SPI chip select, active low, asynchronous
o_RegisterWriteEnable  output  1  one-cycle write strobe
o_RegisterWriteNumber  output  16  register number for the current write
o_RegisterWriteValue  output  8  register value for the current write
o_FrameError  output  1  one-cycle pulse when a frame ends on a partial header or partial data byte
o_Busy  output  1  high while CS is seen asserted and the block is in HEADER or DATA

Behaviour:
- Clocking and reset:
  - One clock domain (i_Clock). Reset is synchronous and active-high.
  - Reset values: all outputs 0; state WAIT_IDLE; bit counter, shift register and address register all 0.
- Synchronisation:
  - SCK, MOSI and CS_N each pass through SYNC_STAGES flops of equal depth, so their relative ordering is preserved.
  - A rising SCK edge is detected from the last two synchronised SCK samples.
  - MOSI is taken from the synchronised stage aligned with that edge.
- Input timing requirement: SCK high time and low time must each be at least SYNC_STAGES+2 i_Clock periods. Behaviour outside this is undefined.
- A detected SCK edge is processed only when synchronised CS_N is low in the same cycle.
- State machine:
  - WAIT_IDLE: entered from reset. Moves to IDLE once synchronised CS_N is high. This discards any frame already in progress when reset was applied.
  - IDLE: moves to HEADER when CS_N goes low. On entry to HEADER, bit counter is cleared.
  - HEADER: shifts 16 bits MSB first. On the 16th bit:
    - the shifted value is loaded into the address register;
    - state moves to DATA;
    - bit counter is cleared.
  - DATA: shifts 8 bits. On the 8th bit, in the next cycle:
    - o_RegisterWriteEnable = 1 for exactly one cycle;
    - o_RegisterWriteNumber = address register;
    - o_RegisterWriteValue = the assembled byte.
    At the same time, the address register is incremented by ADDR_INCREMENT, modulo 2^16 (0xFFFF + 1 = 0x0000). State stays in DATA for the next byte.
- Latency: the strobe is asserted 1 i_Clock cycle after the cycle in which the completing synchronised SCK edge is detected.
- Output hold: o_RegisterWriteNumber and o_RegisterWriteValue hold their last written values between strobes. They update only together with the strobe.
- CS_N rising, from HEADER or DATA: return to IDLE. Then:
  - HEADER with 1..15 bits, or DATA with 1..7 bits: o_FrameError pulses for one cycle; no write is issued.
  - HEADER with 0 bits, or DATA with 0 bits (header-only frame, or a clean end after whole bytes): no error.
- A SCK edge in the same cycle that synchronised CS_N is high is ignored.
- o_Busy is 1 in HEADER and DATA, and 0 otherwise.
- Reset mid-frame: the current byte is dropped and no write or error is produced. The block re-arms only after CS_N has been observed high.
- o_RegisterWriteEnable and o_FrameError never assert in the same cycle.

Test Plan:
- Single write: CS low, shift 0xC0 0x05 0x7F, CS high -> exactly one strobe, Number=0xC005, Value=0x7F; o_FrameError stays 0.
- Burst: header 0xC100, data 0x11 0x22 0x33 -> three strobes: (0xC100,0x11), (0xC101,0x22), (0xC102,0x33); outputs hold (0xC102,0x33) afterwards.
- Address wrap: header 0xFFFF, data 0xAA 0xBB -> strobes at (0xFFFF,0xAA) then (0x0000,0xBB).
- Aborted byte: header 0xC005, then 3 data bits, CS high -> no strobe, one-cycle o_FrameError. A following full frame (0x8000, 0x01) writes correctly.
- Header-only and partial header: 16 header bits then CS high -> no strobe, no error. 5 header bits then CS high -> one-cycle o_FrameError, no strobe.
- Reset mid-frame: CS low, 10 bits shifted, reset asserted 1 cycle, remaining 14 bits clocked with CS still low -> no strobe, no error, o_Busy=0. After CS high, the new frame 0xC200 0x44 writes (0xC200,0x44).
